debug_unit: RTL

Run-control and state-dump block between the host UART and the MIPS pipeline top. It owns the pipeline's `clkEnable` and supports three modes: free-running until a halt instruction, single-step, and dump-only. After a step or a halt it serialises a frozen snapshot of the pipeline over a byte-wide TX handshake: cycle count, PC, register file and data memory. It consumes the pipeline's debug outputs `instruction`, `PC_IFID`, `Registers` and `Memorias`.

---
 rtl/debug_unit.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/debug_unit.sv
// debug_unit: run control and state dump for the MIPS pipeline.
// Owns the pipeline clock enable and supports three modes: free-run until a
// halt opcode, single-step, and dump-only. After a step or a halt, or on a
// dump command, it serialises a 174-byte snapshot (cycle count, PC,
// register file, data memory) over a byte-wide TX handshake.
//
// TX handshake: tx_start is a one-cycle strobe that offers tx_data. tx_data
// stays stable until the UART answers with a one-cycle tx_done. Exactly one
// byte is outstanding at a time. A tx_done while no byte is outstanding is
// ignored. The next byte (or the exit from SEND after the last byte) follows
// one cycle after tx_done is sampled.
module debug_unit #(
  parameter logic [7:0] CMD_RUN  = 8'h63,
  parameter logic [7:0] CMD_STEP = 8'h73,
  parameter logic [7:0] CMD_DUMP = 8'h64,
  parameter logic [5:0] HALT_OP  = 6'h3F
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          tx_done,
  input  logic [31:0]   instruction,
  input  logic [9:0]    pc,
  input  logic [1023:0] registers,
  input  logic [319:0]  memorias,
  output logic          clk_enable,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic          halted,
  output logic [31:0]   cycle_count,
  output logic [2:0]    state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RUN  = 3'd1;
  localparam logic [2:0] S_STEP = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  localparam logic [7:0] LAST_BYTE = 8'd173;

  // Dump cursor and handshake bookkeeping.
  logic [7:0]    byte_idx;
  logic          pending;     // a byte has been offered and not yet acknowledged
  logic          frame_done;  // last byte acknowledged; leave SEND next cycle
  logic [2:0]    ret_state;   // where SEND returns to

  logic [1391:0] frame;
  logic [7:0]    cur_byte;
  logic          halt_seen;

  // The snapshot is read live; the pipeline is frozen while SEND runs, so the
  // fields cannot move under the cursor. Byte 0 is the LSB of cycle_count.
  assign frame     = {memorias, registers, 6'b0, pc, cycle_count};
  assign cur_byte  = frame[{byte_idx, 3'b000} +: 8];
  assign halt_seen = clk_enable && (instruction[31:26] == HALT_OP);

  // Run-control FSM, cycle counter and TX sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      ret_state   <= S_IDLE;
      clk_enable  <= 1'b0;
      tx_start    <= 1'b0;
      tx_data     <= 8'd0;
      halted      <= 1'b0;
      cycle_count <= 32'd0;
      byte_idx    <= 8'd0;
      pending     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      // Counts every edge at which the pipeline advanced; wraps freely.
      if (clk_enable) cycle_count <= cycle_count + 32'd1;

      case (state)
        S_IDLE: begin
          if (rx_valid) begin
            if (rx_data == CMD_RUN) begin
              state      <= S_RUN;
              clk_enable <= 1'b1;
            end else if (rx_data == CMD_STEP) begin
              state      <= S_STEP;
              clk_enable <= 1'b1;
            end else if (rx_data == CMD_DUMP) begin
              state     <= S_SEND;
              ret_state <= S_IDLE;
            end
          end
        end

        S_RUN: begin
          // The pipeline still advances at this edge; it freezes afterwards.
          if (halt_seen) begin
            clk_enable <= 1'b0;
            halted     <= 1'b1;
            ret_state  <= S_DONE;
            state      <= S_SEND;
          end
        end

        S_STEP: begin
          clk_enable <= 1'b0;
          state      <= S_SEND;
          if (halt_seen) begin
            halted    <= 1'b1;
            ret_state <= S_DONE;
          end else begin
            ret_state <= S_IDLE;
          end
        end

        S_SEND: begin
          if (frame_done) begin
            frame_done <= 1'b0;
            state      <= ret_state;
          end else if (!pending) begin
            tx_start <= 1'b1;
            tx_data  <= cur_byte;
            pending  <= 1'b1;
          end else if (tx_done) begin
            pending <= 1'b0;
            if (byte_idx == LAST_BYTE) begin
              byte_idx   <= 8'd0;
              frame_done <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 8'd1;
            end
          end
        end

        S_DONE: begin
          // Terminal: only reset leaves this state.
        end

        default: begin
          state      <= S_IDLE;
          clk_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
